// File: rtl/ramio_initiator.sv
// ramio_initiator: turns CPU load/store requests into RAMIO port-A accesses.
// Aligned accesses are issued as one beat at their native size. Misaligned
// half/word accesses are split into byte beats. Load data is reassembled and
// extended before a one-cycle response pulse.
// Ports:
//   clk, rst            clock (rising edge), async active-high reset
//   req_valid/req_ready request handshake; req_ready is high only in IDLE
//   req_we/req_size/req_signed/req_addr/req_wdata  request payload
//   rsp_valid/rsp_err/rsp_rdata                    completion pulse and result
//   weA/reA/addrA/dinA/doutA                       RAMIO port A
module ramio_initiator #(
  parameter int unsigned ADDR_WIDTH = 13,
  parameter int unsigned RD_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [1:0]            req_size,
  input  logic                  req_signed,
  input  logic [ADDR_WIDTH+1:0] req_addr,
  input  logic [31:0]           req_wdata,
  output logic                  rsp_valid,
  output logic                  rsp_err,
  output logic [31:0]           rsp_rdata,
  output logic [1:0]            weA,
  output logic [2:0]            reA,
  output logic [ADDR_WIDTH+1:0] addrA,
  output logic [31:0]           dinA,
  input  logic [31:0]           doutA
);

  localparam int unsigned AW = ADDR_WIDTH + 2;
  localparam int unsigned WW = (RD_LATENCY > 1) ? $clog2(RD_LATENCY) : 1;

  typedef enum logic [1:0] {IDLE, ACCESS, WAIT, RESP} state_t;

  state_t          state, stateNxt;
  logic            opWe, opWeNxt;
  logic            opSigned, opSignedNxt;
  logic            opSplit, opSplitNxt;
  logic [1:0]      opSize, opSizeNxt;
  logic [AW-1:0]   opAddr, opAddrNxt;
  logic [31:0]     opWdata, opWdataNxt;
  logic [1:0]      beatCnt, beatCntNxt;
  logic [1:0]      beatLast, beatLastNxt;
  logic [WW-1:0]   waitCnt, waitCntNxt;
  logic [31:0]     asmData, asmDataNxt;

  logic [1:0]      weANxt;
  logic [2:0]      reANxt;
  logic [AW-1:0]   addrANxt;
  logic [31:0]     dinANxt;
  logic            rspValidNxt;
  logic            rspErrNxt;
  logic [31:0]     rspRdataNxt;

  // Final sign/zero extension of the assembled load data.
  function automatic logic [31:0] extend(input logic [1:0] size, input logic sgn,
                                         input logic [31:0] a);
    case (size)
      2'b01:   extend = {{24{sgn & a[7]}}, a[7:0]};
      2'b10:   extend = {{16{sgn & a[15]}}, a[15:0]};
      default: extend = a;
    endcase
  endfunction

  assign req_ready = !rst && (state == IDLE);

  // Next state, latched request, and next values of all registered outputs.
  always_comb begin
    stateNxt    = state;
    opWeNxt     = opWe;
    opSignedNxt = opSigned;
    opSplitNxt  = opSplit;
    opSizeNxt   = opSize;
    opAddrNxt   = opAddr;
    opWdataNxt  = opWdata;
    beatCntNxt  = beatCnt;
    beatLastNxt = beatLast;
    waitCntNxt  = waitCnt;
    asmDataNxt  = asmData;
    weANxt      = 2'b00;
    reANxt      = 3'b000;
    addrANxt    = addrA;
    dinANxt     = dinA;
    rspValidNxt = 1'b0;
    rspErrNxt   = 1'b0;
    rspRdataNxt = rsp_rdata;

    case (state)
      IDLE: begin
        if (req_valid) begin
          opWeNxt     = req_we;
          opSignedNxt = req_signed;
          opSizeNxt   = req_size;
          opAddrNxt   = req_addr;
          opWdataNxt  = req_wdata;
          opSplitNxt  = ((req_size == 2'b10) && req_addr[0]) ||
                        ((req_size == 2'b11) && (req_addr[1:0] != 2'b00));
          beatLastNxt = !opSplitNxt ? 2'd0 : ((req_size == 2'b11) ? 2'd3 : 2'd1);
          beatCntNxt  = 2'd0;
          asmDataNxt  = '0;
          stateNxt    = (req_size == 2'b00) ? RESP : ACCESS;
        end
      end
      ACCESS: begin
        if (!opWe) begin
          waitCntNxt = '0;
          stateNxt   = WAIT;
        end else if (beatCnt == beatLast) begin
          stateNxt = RESP;
        end else begin
          beatCntNxt = beatCnt + 2'd1;
          stateNxt   = ACCESS;
        end
      end
      WAIT: begin
        if (waitCnt == WW'(RD_LATENCY - 1)) begin
          // Split loads gather one byte per beat; aligned loads take the whole word.
          if (opSplit) asmDataNxt[{beatCnt, 3'b000} +: 8] = doutA[7:0];
          else         asmDataNxt = doutA;
          if (beatCnt == beatLast) begin
            stateNxt = RESP;
          end else begin
            beatCntNxt = beatCnt + 2'd1;
            stateNxt   = ACCESS;
          end
        end else begin
          waitCntNxt = waitCnt + WW'(1);
        end
      end
      RESP:    stateNxt = IDLE;
      default: stateNxt = IDLE;
    endcase

    // Beat drive for the upcoming ACCESS cycle; address wraps at AW bits.
    if (stateNxt == ACCESS) begin
      addrANxt = opAddrNxt + AW'(beatCntNxt);
      if (opWeNxt) begin
        weANxt  = opSplitNxt ? 2'b01 : opSizeNxt;
        dinANxt = opSplitNxt ? 32'(8'(opWdataNxt >> {beatCntNxt, 3'b000})) : opWdataNxt;
      end else begin
        reANxt  = opSplitNxt ? 3'b001 : {1'b0, opSizeNxt};
        dinANxt = '0;
      end
    end

    if (stateNxt == RESP) begin
      rspValidNxt = 1'b1;
      rspErrNxt   = (opSizeNxt == 2'b00);
      rspRdataNxt = (opWeNxt || rspErrNxt) ? '0 : extend(opSizeNxt, opSignedNxt, asmDataNxt);
    end
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      opWe      <= 1'b0;
      opSigned  <= 1'b0;
      opSplit   <= 1'b0;
      opSize    <= 2'b00;
      opAddr    <= '0;
      opWdata   <= '0;
      beatCnt   <= 2'd0;
      beatLast  <= 2'd0;
      waitCnt   <= '0;
      asmData   <= '0;
      weA       <= 2'b00;
      reA       <= 3'b000;
      addrA     <= '0;
      dinA      <= '0;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      state     <= stateNxt;
      opWe      <= opWeNxt;
      opSigned  <= opSignedNxt;
      opSplit   <= opSplitNxt;
      opSize    <= opSizeNxt;
      opAddr    <= opAddrNxt;
      opWdata   <= opWdataNxt;
      beatCnt   <= beatCntNxt;
      beatLast  <= beatLastNxt;
      waitCnt   <= waitCntNxt;
      asmData   <= asmDataNxt;
      weA       <= weANxt;
      reA       <= reANxt;
      addrA     <= addrANxt;
      dinA      <= dinANxt;
      rsp_valid <= rspValidNxt;
      rsp_err   <= rspErrNxt;
      rsp_rdata <= rspRdataNxt;
    end
  end

endmodule

// File: tb/tb_ramio_initiator.sv
// Bench for ramio_initiator: byte-addressed RAMIO memory model, scoreboard for
// responses (data, error flag and arrival cycle) and a log of RAMIO beats.
module tb_ramio_initiator;

  localparam int unsigned ADDR_WIDTH = 13;
  localparam int unsigned AW         = ADDR_WIDTH + 2;
  localparam int unsigned MEMB       = 1 << AW;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
    logic [31:0] cyc;
  } exp_t;

  typedef struct packed {
    logic [1:0]    we;
    logic [2:0]    re;
    logic [AW-1:0] addr;
    logic [31:0]   din;
  } beat_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic          req_we = 1'b0;
  logic [1:0]    req_size = 2'b00;
  logic          req_signed = 1'b0;
  logic [AW-1:0] req_addr = '0;
  logic [31:0]   req_wdata = '0;
  logic          rsp_valid;
  logic          rsp_err;
  logic [31:0]   rsp_rdata;
  logic [1:0]    weA;
  logic [2:0]    reA;
  logic [AW-1:0] addrA;
  logic [31:0]   dinA;
  logic [31:0]   doutA = '0;

  int   checks = 0;
  int   errors = 0;
  logic [31:0] cyc = '0;
  int   hsCount = 0;
  exp_t expQ[$];
  beat_t beatLog[$];
  beat_t expBeats[$];
  logic [7:0] mem [0:MEMB-1];

  ramio_initiator #(.ADDR_WIDTH(ADDR_WIDTH), .RD_LATENCY(1)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
    .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_err(rsp_err), .rsp_rdata(rsp_rdata),
    .weA(weA), .reA(reA), .addrA(addrA), .dinA(dinA), .doutA(doutA)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 32'd1;

  always @(posedge clk) if (req_valid && req_ready) hsCount <= hsCount + 1;

  function automatic int nbytes(input logic [1:0] s);
    return (s == 2'b01) ? 1 : (s == 2'b10) ? 2 : 4;
  endfunction

  function automatic logic [31:0] rdModel(input logic [2:0] re, input logic [AW-1:0] a);
    logic [31:0] v;
    int n;
    v = '0;
    n = nbytes(re[1:0]);
    for (int k = 0; k < n; k++) v[8*k +: 8] = mem[AW'(a + AW'(k))];
    if (re[2]) v = (n == 1) ? {{24{v[7]}}, v[7:0]} : (n == 2) ? {{16{v[15]}}, v[15:0]} : v;
    return v;
  endfunction

  // RAMIO memory: little-endian bytes, one-cycle registered read.
  always @(posedge clk) begin
    if (weA != 2'b00)
      for (int k = 0; k < nbytes(weA); k++) mem[AW'(addrA + AW'(k))] <= dinA[8*k +: 8];
    if (reA[1:0] != 2'b00) doutA <= rdModel(reA, addrA);
  end

  // Beat log and response scoreboard.
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (weA != 2'b00 || reA != 3'b000) beatLog.push_back('{weA, reA, addrA, dinA});
      if (rsp_valid) begin
        checks++;
        if (expQ.size() == 0) begin
          errors++;
          $display("FAIL unexpected_rsp: got rdata=%h err=%b at cycle %0d, required no response",
                   rsp_rdata, rsp_err, cyc);
        end else begin
          e = expQ.pop_front();
          if (rsp_rdata !== e.rdata || rsp_err !== e.err || cyc !== e.cyc) begin
            errors++;
            $display("FAIL rsp: got rdata=%h err=%b cycle=%0d, required rdata=%h err=%b cycle=%0d",
                     rsp_rdata, rsp_err, cyc, e.rdata, e.err, e.cyc);
          end
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, got, want);
    end
  endtask

  task automatic addBeat(input logic [1:0] we, input logic [2:0] re,
                         input logic [AW-1:0] a, input logic [31:0] d);
    expBeats.push_back('{we, re, a, d});
  endtask

  // Issue one request; the handshake cycle N is the cycle where ready is seen high.
  task automatic issue(input logic we, input logic [1:0] size, input logic sgn,
                       input logic [AW-1:0] a, input logic [31:0] wdata,
                       input logic [31:0] expData, input logic expErr,
                       input int lat, input bit track);
    int guard;
    @(negedge clk);
    beatLog.delete();
    req_we = we; req_size = size; req_signed = sgn; req_addr = a; req_wdata = wdata;
    req_valid = 1'b1;
    guard = 0;
    while (!req_ready && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (!req_ready) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: got req_ready=0 for %0d cycles, required 1", guard);
    end else if (track) begin
      expQ.push_back('{expData, expErr, cyc + 32'(lat)});
    end
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic waitDone();
    int g;
    g = 0;
    while (expQ.size() != 0 && g < 60) begin
      @(negedge clk);
      g++;
    end
    if (expQ.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL rsp_timeout: got %0d pending responses, required 0", expQ.size());
      expQ.delete();
    end
    @(negedge clk);
  endtask

  task automatic checkBeats(input string name);
    checks++;
    if (beatLog.size() != expBeats.size()) begin
      errors++;
      $display("FAIL %s_beat_count: got %0d, required %0d", name, beatLog.size(), expBeats.size());
    end else begin
      for (int i = 0; i < expBeats.size(); i++) begin
        checks++;
        if (beatLog[i] !== expBeats[i]) begin
          errors++;
          $display("FAIL %s_beat%0d: got we=%b re=%b addr=%0d din=%h, required we=%b re=%b addr=%0d din=%h",
                   name, i, beatLog[i].we, beatLog[i].re, beatLog[i].addr, beatLog[i].din,
                   expBeats[i].we, expBeats[i].re, expBeats[i].addr, expBeats[i].din);
        end
      end
    end
    beatLog.delete();
    expBeats.delete();
  endtask

  initial begin
    int g;
    int hs0;
    for (int i = 0; i < MEMB; i++) mem[i] = 8'h00;

    // Reset state.
    #2;
    chk("rst_weA", 32'(weA), 32'd0);
    chk("rst_reA", 32'(reA), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_rdata", rsp_rdata, 32'd0);
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("idle_req_ready", 32'(req_ready), 32'd1);

    // Aligned word store then load.
    addBeat(2'b11, 3'b000, 15'd0, 32'h78563412);
    issue(1'b1, 2'b11, 1'b0, 15'd0, 32'h78563412, 32'h0, 1'b0, 2, 1'b1);
    waitDone(); checkBeats("t1_store");
    addBeat(2'b00, 3'b011, 15'd0, 32'h0);
    issue(1'b0, 2'b11, 1'b0, 15'd0, 32'h0, 32'h78563412, 1'b0, 3, 1'b1);
    waitDone(); checkBeats("t1_load");

    // Misaligned word store/load at 5.
    addBeat(2'b01, 3'b000, 15'd5, 32'hDD);
    addBeat(2'b01, 3'b000, 15'd6, 32'hCC);
    addBeat(2'b01, 3'b000, 15'd7, 32'hBB);
    addBeat(2'b01, 3'b000, 15'd8, 32'hAA);
    issue(1'b1, 2'b11, 1'b0, 15'd5, 32'hAABBCCDD, 32'h0, 1'b0, 5, 1'b1);
    waitDone(); checkBeats("t2_store");
    for (int i = 0; i < 4; i++) addBeat(2'b00, 3'b001, 15'(5 + i), 32'h0);
    issue(1'b0, 2'b11, 1'b0, 15'd5, 32'h0, 32'hAABBCCDD, 1'b0, 9, 1'b1);
    waitDone(); checkBeats("t2_load");

    // Extension.
    addBeat(2'b11, 3'b000, 15'd8, 32'hFFFEFDFC);
    issue(1'b1, 2'b11, 1'b0, 15'd8, 32'hFFFEFDFC, 32'h0, 1'b0, 2, 1'b1);
    waitDone(); checkBeats("t3_store");
    addBeat(2'b00, 3'b001, 15'd8, 32'h0);
    issue(1'b0, 2'b01, 1'b1, 15'd8, 32'h0, 32'hFFFFFFFC, 1'b0, 3, 1'b1);
    waitDone(); checkBeats("t3_sbyte");
    addBeat(2'b00, 3'b001, 15'd8, 32'h0);
    issue(1'b0, 2'b01, 1'b0, 15'd8, 32'h0, 32'h000000FC, 1'b0, 3, 1'b1);
    waitDone(); checkBeats("t3_ubyte");
    addBeat(2'b00, 3'b001, 15'd9, 32'h0);
    addBeat(2'b00, 3'b001, 15'd10, 32'h0);
    issue(1'b0, 2'b10, 1'b1, 15'd9, 32'h0, 32'hFFFFFEFD, 1'b0, 5, 1'b1);
    waitDone(); checkBeats("t3_shalf");
    addBeat(2'b00, 3'b010, 15'd10, 32'h0);
    issue(1'b0, 2'b10, 1'b0, 15'd10, 32'h0, 32'h0000FFFE, 1'b0, 3, 1'b1);
    waitDone(); checkBeats("t3_uhalf");

    // Async reset during beat 2 of a misaligned word load.
    issue(1'b0, 2'b11, 1'b0, 15'd5, 32'h0, 32'h0, 1'b0, 9, 1'b0);
    g = 0;
    while (!(reA != 3'b000 && addrA == 15'd7) && g < 30) begin
      @(negedge clk);
      g++;
    end
    chk("t5_reach_beat2", 32'(addrA), 32'd7);
    rst = 1'b1;
    #1;
    chk("t5_weA", 32'(weA), 32'd0);
    chk("t5_reA", 32'(reA), 32'd0);
    chk("t5_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("t5_req_ready", 32'(req_ready), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (12) @(negedge clk);
    beatLog.delete();
    addBeat(2'b00, 3'b011, 15'd0, 32'h0);
    issue(1'b0, 2'b11, 1'b0, 15'd0, 32'h0, 32'h78563412, 1'b0, 3, 1'b1);
    waitDone(); checkBeats("t5_after");

    // Illegal size: error at N+1, no RAMIO access.
    issue(1'b0, 2'b00, 1'b0, 15'd3, 32'h0, 32'h0, 1'b1, 1, 1'b1);
    waitDone(); checkBeats("t6_err");

    // req_valid held across a busy request is accepted once.
    hs0 = hsCount;
    @(negedge clk);
    beatLog.delete();
    req_we = 1'b1; req_size = 2'b11; req_signed = 1'b0; req_addr = 15'd12;
    req_wdata = 32'h01020304; req_valid = 1'b1;
    #1;
    chk("t6_ready_idle", 32'(req_ready), 32'd1);
    expQ.push_back('{32'h0, 1'b0, cyc + 32'd2});
    addBeat(2'b11, 3'b000, 15'd12, 32'h01020304);
    @(negedge clk);
    chk("t6_ready_busy", 32'(req_ready), 32'd0);
    @(negedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    chk("t6_ready_after_resp", 32'(req_ready), 32'd1);
    waitDone(); checkBeats("t6_hold");
    chk("t6_accept_once", 32'(hsCount - hs0), 32'd1);

    // Wrap at the top of memory.
    addBeat(2'b01, 3'b000, 15'(MEMB - 2), 32'h44);
    addBeat(2'b01, 3'b000, 15'(MEMB - 1), 32'h33);
    addBeat(2'b01, 3'b000, 15'd0, 32'h22);
    addBeat(2'b01, 3'b000, 15'd1, 32'h11);
    issue(1'b1, 2'b11, 1'b0, 15'(MEMB - 2), 32'h11223344, 32'h0, 1'b0, 5, 1'b1);
    waitDone(); checkBeats("t4_store");
    addBeat(2'b00, 3'b001, 15'(MEMB - 2), 32'h0);
    addBeat(2'b00, 3'b001, 15'(MEMB - 1), 32'h0);
    addBeat(2'b00, 3'b001, 15'd0, 32'h0);
    addBeat(2'b00, 3'b001, 15'd1, 32'h0);
    issue(1'b0, 2'b11, 1'b0, 15'(MEMB - 2), 32'h0, 32'h11223344, 1'b0, 9, 1'b1);
    waitDone(); checkBeats("t4_load");

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
